hex_display_ctrl: RTL



---
 rtl/hex_display_ctrl_pkg.sv | 35 +++
 rtl/hex_display_ctrl_key_debounce.sv | 70 +++++++
 rtl/hex_display_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hex_display_ctrl_pkg.sv
// rtl/hex_display_ctrl_pkg.sv - shared constants, debounce state type and blank-mask helper
// Package display_pkg:
//   NUM_DIGITS, NIBBLE_W  - HEX display geometry
//   db_state_t            - key debounce FSM states
//   lz_blank_mask()       - leading-zero blank mask for a 24-bit value (digit 0 never blanked)
package display_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int NIBBLE_W   = 4;

   typedef enum logic [1:0] {
      UP      = 2'd0,
      WAIT_DN = 2'd1,
      DOWN    = 2'd2,
      WAIT_UP = 2'd3
   } db_state_t;

   // Digit k is dark when nibbles k..5 are all zero. The scan runs from the
   // most significant digit down so 'zeros' stays set only through the run
   // of leading zeros.
   function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(
      input logic [NUM_DIGITS*NIBBLE_W-1:0] v
   );
      logic [NUM_DIGITS-1:0] mask;
      logic                  zeros;
      mask  = '0;
      zeros = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zeros   = zeros & (v[k*NIBBLE_W +: NIBBLE_W] == '0);
         mask[k] = zeros;
      end
      return mask;
   endfunction

endpackage

// File: rtl/hex_display_ctrl_key_debounce.sv
// rtl/hex_display_ctrl_key_debounce.sv - push-button synchronizer and debounce FSM
// Module key_debounce #(DB_CYCLES):
//   clk, rst_n   in   clock, asynchronous active-low reset
//   i_btn_n      in   raw active-low key, asynchronous to clk
//   o_press      out  one-cycle pulse on each debounced press
module key_debounce
   import display_pkg::*;
#(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int             CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   db_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_low;

   assign w_low = ~r_sync2;

   // Synchronizer resets to 'released' so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= UP;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         case (r_state)
            UP: begin
               if (w_low) begin
                  r_state <= WAIT_DN;
                  r_cnt   <= '0;
               end
            end
            WAIT_DN: begin
               if (!w_low)                r_state <= UP;
               else if (r_cnt == CNT_LAST) r_state <= DOWN;
               else                       r_cnt   <= r_cnt + 1'b1;
            end
            DOWN: begin
               if (!w_low) begin
                  r_state <= WAIT_UP;
                  r_cnt   <= '0;
               end
            end
            WAIT_UP: begin
               if (w_low)                 r_state <= DOWN;
               else if (r_cnt == CNT_LAST) r_state <= UP;
               else                       r_cnt   <= r_cnt + 1'b1;
            end
            default: r_state <= UP;
         endcase
      end
   end

   // Decoded from registered state: high in the cycle of the last stable low
   // sample, so the page register toggles on the same edge the FSM enters DOWN.
   assign o_press = (r_state == WAIT_DN) && w_low && (r_cnt == CNT_LAST);

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - throttled, pageable HEX display formatter for a 32-bit value
// Optional feature macro: ZERO_BLANK_EN (leading-zero blanking).
// Ports:
//   clk, rst_n     in   clock, asynchronous active-low reset
//   data_i[31:0]   in   value to display, qualified by valid_i
//   valid_i        in   data qualifier
//   freeze_i       in   1 = hold current display contents
//   page_btn_n_i   in   raw active-low page key
//   digit_o[23:0]  out  six nibbles, digit 0 at [3:0]
//   blank_o[5:0]   out  1 = digit must be forced dark
//   page_o         out  0 = low 24 bits, 1 = high 8 bits
//   update_o       out  pulse in the cycle the display register reloads
module hex_display_ctrl
   import display_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int REFRESH_HZ  = 10,
   parameter int DEBOUNCE_MS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_i,
   input  logic        valid_i,
   input  logic        freeze_i,
   input  logic        page_btn_n_i,
   output logic [23:0] digit_o,
   output logic [5:0]  blank_o,
   output logic        page_o,
   output logic        update_o
);

   localparam int              TICK_CYCLES = CLK_HZ / REFRESH_HZ;
   localparam int              TICK_W      = $clog2(TICK_CYCLES);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam int              DB_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;

`ifdef ZERO_BLANK_EN
   localparam logic [NUM_DIGITS-1:0] RST_BLANK = 6'b111110;
`else
   localparam logic [NUM_DIGITS-1:0] RST_BLANK = 6'b000000;
`endif

   logic [TICK_W-1:0]           r_tick_cnt;
   logic [31:0]                 r_shadow;
   logic [31:0]                 r_disp;
   logic                        r_page;
   logic [23:0]                 r_digit;
   logic [NUM_DIGITS-1:0]       r_blank;
   logic                        w_tick;
   logic                        w_load;
   logic                        w_press;
   logic [31:0]                 w_disp_next;
   logic [23:0]                 w_digit;
   logic [NUM_DIGITS-1:0]       w_blank;

   key_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_key_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (page_btn_n_i),
      .o_press (w_press)
   );

   assign w_tick = (r_tick_cnt == TICK_LAST);
   assign w_load = w_tick & ~freeze_i;
   // A valid word arriving in the tick cycle bypasses the shadow.
   assign w_disp_next = w_load ? (valid_i ? data_i : r_shadow) : r_disp;

   // Render from the next display value so digits show one cycle after the
   // load; page comes from the register, so a page flip re-renders one cycle
   // after page_o changes.
   always_comb begin
      w_digit = w_disp_next[23:0];
      w_blank = '0;
`ifdef ZERO_BLANK_EN
      w_blank = lz_blank_mask(w_disp_next[23:0]);
`endif
      if (r_page) begin
         w_digit = {16'h0000, w_disp_next[31:24]};
         w_blank = 6'b111100;
`ifdef ZERO_BLANK_EN
         w_blank[1] = (w_disp_next[31:28] == 4'h0);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
         r_shadow   <= '0;
         r_disp     <= '0;
         r_page     <= 1'b0;
         r_digit    <= '0;
         r_blank    <= RST_BLANK;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (valid_i) r_shadow <= data_i;
         r_disp  <= w_disp_next;
         if (w_press) r_page <= ~r_page;
         r_digit <= w_digit;
         r_blank <= w_blank;
      end
   end

   assign digit_o  = r_digit;
   assign blank_o  = r_blank;
   assign page_o   = r_page;
   assign update_o = w_load;

endmodule
